if_id_buffer: RTL and testbench

IF_ID_BUFFER -- requirements
Module: if_id_buffer

---
 rtl/if_id_buffer_pkg.sv | 23 ++
 rtl/if_id_buffer_pc_gen.sv | 16 +
 rtl/if_id_buffer.sv | 193 +++++++++++++++++++
 tb/tb_if_id_buffer.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/if_id_buffer_pkg.sv
// Shared types and constants for the IF/ID skid buffer.
// The state encoding, default fetch base address and NOP word live here.
package if_id_buffer_pkg;

  localparam int          INS_W           = 32;
  localparam int          ADDR_W          = 10;
  localparam logic [31:0] PC_BASE_DEFAULT = 32'h0000_3000;
  localparam logic [31:0] NOP_INS         = 32'h0000_0000;
  localparam logic [31:0] PC_STEP         = 32'h0000_0004;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } ifid_state_t;

  // Word address to byte PC; the add wraps modulo 2^32 by construction.
  function automatic logic [31:0] word_to_byte_pc(input logic [31:0] base,
                                                  input logic [ADDR_W-1:0] addr);
    word_to_byte_pc = base + {20'b0, addr, 2'b00};
  endfunction

endpackage

// File: rtl/if_id_buffer_pc_gen.sv
// ifid_pc_gen: turns the 10-bit instruction word address into the byte PC
// and the PC of the following instruction.
module ifid_pc_gen
  import if_id_buffer_pkg::*;
#(
  parameter logic [31:0] PC_BASE = PC_BASE_DEFAULT
) (
  input  logic [ADDR_W-1:0] addr,
  output logic [31:0]       pc,
  output logic [31:0]       pc4
);

  assign pc  = word_to_byte_pc(PC_BASE, addr);
  assign pc4 = pc + PC_STEP;

endmodule

// File: rtl/if_id_buffer.sv
// if_id_buffer: 2-entry in-order FIFO between fetch and decode.
// Optional macro IFID_PERF_CNT_EN adds the saturating bubble_cnt port.
module if_id_buffer
  import if_id_buffer_pkg::*;
#(
  parameter logic [31:0] PC_BASE = PC_BASE_DEFAULT,
  parameter int          CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst_pc,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [INS_W-1:0]  in_ins,
  input  logic [ADDR_W-1:0] in_addr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [INS_W-1:0]  out_ins,
  output logic [31:0]       out_pc,
  output logic [31:0]       out_pc4
`ifdef IFID_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]  bubble_cnt
`endif
);

  ifid_state_t       state_r;
  ifid_state_t       state_nxt;
  logic              push;
  logic              pop;

  logic [INS_W-1:0]  head_ins_r;
  logic [ADDR_W-1:0] head_addr_r;
  logic [INS_W-1:0]  tail_ins_r;
  logic [ADDR_W-1:0] tail_addr_r;
  logic [ADDR_W-1:0] last_addr_r;

  logic [INS_W-1:0]  head_ins_nxt;
  logic [ADDR_W-1:0] head_addr_nxt;
  logic [INS_W-1:0]  tail_ins_nxt;
  logic [ADDR_W-1:0] tail_addr_nxt;
  logic [ADDR_W-1:0] last_addr_nxt;
  logic [ADDR_W-1:0] pc_addr;

  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready;

  // State register; reset empties the buffer without waiting for clk.
  always_ff @(posedge clk or posedge rst_pc) begin
    if (rst_pc) begin
      state_r <= ST_EMPTY;
    end else begin
      state_r <= state_nxt;
    end
  end

  // Next-state logic; flush overrides every other transition.
  always_comb begin
    state_nxt = state_r;
    case (state_r)
      ST_EMPTY: begin
        if (push) state_nxt = ST_ONE;
        else      state_nxt = ST_EMPTY;
      end
      ST_ONE: begin
        if (push && !pop)      state_nxt = ST_FULL;
        else if (!push && pop) state_nxt = ST_EMPTY;
        else                   state_nxt = ST_ONE;
      end
      ST_FULL: begin
        if (pop) state_nxt = ST_ONE;
        else     state_nxt = ST_FULL;
      end
      default: state_nxt = ST_EMPTY;
    endcase
    if (flush) state_nxt = ST_EMPTY;
    else       state_nxt = state_nxt;
  end

  // Handshake outputs decode the registered state only.
  always_comb begin
    in_ready  = 1'b1;
    out_valid = 1'b0;
    case (state_r)
      ST_EMPTY: begin
        in_ready  = 1'b1;
        out_valid = 1'b0;
      end
      ST_ONE: begin
        in_ready  = 1'b1;
        out_valid = 1'b1;
      end
      ST_FULL: begin
        in_ready  = 1'b0;
        out_valid = 1'b1;
      end
      default: begin
        in_ready  = 1'b1;
        out_valid = 1'b0;
      end
    endcase
  end

  // Entry movement: head is what decode sees, tail only fills in FULL.
  always_comb begin
    head_ins_nxt  = head_ins_r;
    head_addr_nxt = head_addr_r;
    tail_ins_nxt  = tail_ins_r;
    tail_addr_nxt = tail_addr_r;
    if (pop) last_addr_nxt = head_addr_r;
    else     last_addr_nxt = last_addr_r;

    if (flush) begin
      head_ins_nxt = NOP_INS;
    end else begin
      case (state_r)
        ST_EMPTY: begin
          if (push) begin
            head_ins_nxt  = in_ins;
            head_addr_nxt = in_addr;
          end else begin
            head_ins_nxt  = NOP_INS;
          end
        end
        ST_ONE: begin
          if (push && pop) begin
            head_ins_nxt  = in_ins;
            head_addr_nxt = in_addr;
          end else if (push) begin
            tail_ins_nxt  = in_ins;
            tail_addr_nxt = in_addr;
          end else if (pop) begin
            head_ins_nxt  = NOP_INS;
          end else begin
            head_ins_nxt  = head_ins_r;
          end
        end
        ST_FULL: begin
          if (pop) begin
            head_ins_nxt  = tail_ins_r;
            head_addr_nxt = tail_addr_r;
          end else begin
            head_ins_nxt  = head_ins_r;
          end
        end
        default: head_ins_nxt = NOP_INS;
      endcase
    end
  end

  // Output-facing registers: NOP word and last popped address survive EMPTY.
  always_ff @(posedge clk or posedge rst_pc) begin
    if (rst_pc) begin
      head_ins_r  <= NOP_INS;
      last_addr_r <= {ADDR_W{1'b0}};
    end else begin
      head_ins_r  <= head_ins_nxt;
      last_addr_r <= last_addr_nxt;
    end
  end

  // Pure storage, never observed before it is written.
  always_ff @(posedge clk) begin
    head_addr_r <= head_addr_nxt;
    tail_ins_r  <= tail_ins_nxt;
    tail_addr_r <= tail_addr_nxt;
  end

  assign out_ins = head_ins_r;
  assign pc_addr = (state_r == ST_EMPTY) ? last_addr_r : head_addr_r;

  ifid_pc_gen #(
    .PC_BASE (PC_BASE)
  ) u_pc_gen (
    .addr (pc_addr),
    .pc   (out_pc),
    .pc4  (out_pc4)
  );

`ifdef IFID_PERF_CNT_EN
  // Counts cycles where decode wanted an instruction and none was there.
  always_ff @(posedge clk or posedge rst_pc) begin
    if (rst_pc) begin
      bubble_cnt <= {CNT_W{1'b0}};
    end else if (out_ready && !out_valid && (bubble_cnt != {CNT_W{1'b1}})) begin
      bubble_cnt <= bubble_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      bubble_cnt <= bubble_cnt;
    end
  end
`endif

endmodule

// File: tb/tb_if_id_buffer.sv
// Scoreboard bench for if_id_buffer: the driver queues expected pops,
// a negedge monitor compares every decode-side handshake against the queue.
module tb_if_id_buffer;

  typedef struct {
    logic [31:0] ins;
    logic [31:0] pc;
    logic [31:0] pc4;
  } exp_t;

  logic        clk;
  logic        rst_pc;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_ins;
  logic [9:0]  in_addr;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_ins;
  logic [31:0] out_pc;
  logic [31:0] out_pc4;
`ifdef IFID_PERF_CNT_EN
  logic [15:0] bubble_cnt;
`endif

  exp_t q[$];
  int   n_vec;
  int   n_err;

  if_id_buffer dut (
    .clk       (clk),
    .rst_pc    (rst_pc),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_ins    (in_ins),
    .in_addr   (in_addr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ins   (out_ins),
    .out_pc    (out_pc),
    .out_pc4   (out_pc4)
`ifdef IFID_PERF_CNT_EN
    ,
    .bubble_cnt(bubble_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_vec(input logic [31:0] ins, input logic [9:0] addr,
                          input logic [31:0] pc, input logic [31:0] pc4);
    exp_t e;
    in_valid = 1'b1;
    in_ins   = ins;
    in_addr  = addr;
    e.ins = ins;
    e.pc  = pc;
    e.pc4 = pc4;
    q.push_back(e);
  endtask

  // Monitor: every pop seen by decode must match the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_pc && out_valid && out_ready) begin
        if (q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL sb_unexpected: got ins %h pc %h expected no output", out_ins, out_pc);
        end else begin
          e = q.pop_front();
          chk("sb_ins", out_ins, e.ins);
          chk("sb_pc", out_pc, e.pc);
          chk("sb_pc4", out_pc4, e.pc4);
        end
      end
    end
  end

  initial begin
    n_vec     = 0;
    n_err     = 0;
    rst_pc    = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_ins    = 32'h0;
    in_addr   = 10'd0;
    out_ready = 1'b0;

    repeat (2) tick();
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_ins", out_ins, 32'h0000_0000);
    chk("rst_out_pc", out_pc, 32'h0000_3000);
    chk("rst_out_pc4", out_pc4, 32'h0000_3004);
`ifdef IFID_PERF_CNT_EN
    chk("rst_bubble", {16'd0, bubble_cnt}, 32'd0);
`endif
    rst_pc = 1'b0;

    // First edge after reset release accepts; one-cycle latency.
    push_vec(32'h2008_0005, 10'd0, 32'h0000_3000, 32'h0000_3004);
    tick();
    in_valid = 1'b0;
    chk("lat_out_valid", {31'd0, out_valid}, 32'd1);
    chk("lat_out_pc", out_pc, 32'h0000_3000);
    chk("lat_out_pc4", out_pc4, 32'h0000_3004);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("empty_out_valid", {31'd0, out_valid}, 32'd0);
    chk("empty_out_ins", out_ins, 32'h0000_0000);
    chk("empty_hold_pc", out_pc, 32'h0000_3000);

    // Fill to FULL, third push refused, drain in order.
    push_vec(32'h0000_1111, 10'd1, 32'h0000_3004, 32'h0000_3008);
    tick();
    push_vec(32'h0000_2222, 10'd2, 32'h0000_3008, 32'h0000_300C);
    tick();
    chk("full_in_ready", {31'd0, in_ready}, 32'd0);
    in_valid = 1'b1;
    in_ins   = 32'h0000_3333;
    in_addr  = 10'd3;
    tick();
    in_valid = 1'b0;
    chk("full_refuse_in_ready", {31'd0, in_ready}, 32'd0);
    chk("full_head_pc", out_pc, 32'h0000_3004);
    out_ready = 1'b1;
    repeat (2) tick();
    out_ready = 1'b0;
    chk("drain_out_valid", {31'd0, out_valid}, 32'd0);
    chk("drain_hold_pc", out_pc, 32'h0000_3008);

    // ONE with simultaneous push and pop stays ONE.
    push_vec(32'h0000_4444, 10'd4, 32'h0000_3010, 32'h0000_3014);
    tick();
    push_vec(32'h0000_5555, 10'd5, 32'h0000_3014, 32'h0000_3018);
    out_ready = 1'b1;
    tick();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk("pp_out_valid", {31'd0, out_valid}, 32'd1);
    chk("pp_in_ready", {31'd0, in_ready}, 32'd1);
    chk("pp_head_ins", out_ins, 32'h0000_5555);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("pp_empty", {31'd0, out_valid}, 32'd0);

    // Flush from FULL: head consumed once, tail and incoming dropped.
    push_vec(32'h0000_6666, 10'd6, 32'h0000_3018, 32'h0000_301C);
    tick();
    push_vec(32'h0000_7777, 10'd7, 32'h0000_301C, 32'h0000_3020);
    tick();
    flush     = 1'b1;
    in_valid  = 1'b1;
    in_ins    = 32'h0000_8888;
    in_addr   = 10'd8;
    out_ready = 1'b1;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    q.delete();
    chk("flush_out_valid", {31'd0, out_valid}, 32'd0);
    chk("flush_out_ins", out_ins, 32'h0000_0000);
    chk("flush_in_ready", {31'd0, in_ready}, 32'd1);
    chk("flush_hold_pc", out_pc, 32'h0000_3018);
    repeat (2) tick();
    out_ready = 1'b0;
    chk("flush_stays_empty", {31'd0, out_valid}, 32'd0);

    // Top word address wraps the PC into the next 4 KiB page.
    push_vec(32'hDEAD_BEEF, 10'h3FF, 32'h0000_3FFC, 32'h0000_4000);
    tick();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Asynchronous reset between edges discards both entries.
    push_vec(32'h0000_9999, 10'd9, 32'h0000_3024, 32'h0000_3028);
    tick();
    push_vec(32'h0000_AAAA, 10'd10, 32'h0000_3028, 32'h0000_302C);
    tick();
    in_valid = 1'b0;
    #2;
    rst_pc = 1'b1;
    #1;
    chk("async_rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("async_rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("async_rst_out_ins", out_ins, 32'h0000_0000);
    chk("async_rst_out_pc", out_pc, 32'h0000_3000);
    q.delete();
    #2;
    rst_pc = 1'b0;
    push_vec(32'h0000_BBBB, 10'd11, 32'h0000_302C, 32'h0000_3030);
    tick();
    in_valid = 1'b0;
    chk("post_rst_accept", {31'd0, out_valid}, 32'd1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

`ifdef IFID_PERF_CNT_EN
    rst_pc = 1'b1;
    #1;
    chk("bubble_rst", {16'd0, bubble_cnt}, 32'd0);
    rst_pc    = 1'b0;
    out_ready = 1'b1;
    repeat (5) tick();
    chk("bubble_five", {16'd0, bubble_cnt}, 32'd5);
    #2;
    rst_pc = 1'b1;
    #1;
    chk("bubble_async_clear", {16'd0, bubble_cnt}, 32'd0);
    rst_pc    = 1'b0;
    out_ready = 1'b0;
`endif

    tick();
    chk("sb_leftover", q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
